// File: rtl/aes_txn_sequencer_if.sv
// Job, transaction and ACK bus bundle for the AES job sequencer.
// master: sequencer side; slave: host/CSR layer plus bus fabric side.
interface aes_txn_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_key_addr;
  logic [ADDR_W-1:0] job_text_addr;
  logic [ADDR_W-1:0] job_dst_addr;
  logic              job_encdec;
  logic              job_new_key;
  logic              txn_valid;
  logic              txn_ready;
  logic [1:0]        txn_opcode;
  logic [1:0]        txn_source_id;
  logic [1:0]        txn_dest_id;
  logic              txn_encdec;
  logic [ADDR_W-1:0] txn_addr;
  logic              ack_valid;
  logic              ack_ready;
  logic [1:0]        ack_source_id;

  modport master (
    input  job_valid, job_key_addr, job_text_addr, job_dst_addr, job_encdec, job_new_key,
    input  txn_ready, ack_valid, ack_source_id,
    output job_ready, txn_valid, txn_opcode, txn_source_id, txn_dest_id, txn_encdec, txn_addr,
    output ack_ready
  );

  modport slave (
    output job_valid, job_key_addr, job_text_addr, job_dst_addr, job_encdec, job_new_key,
    output txn_ready, ack_valid, ack_source_id,
    input  job_ready, txn_valid, txn_opcode, txn_source_id, txn_dest_id, txn_encdec, txn_addr,
    input  ack_ready
  );
endinterface

// File: rtl/aes_txn_sequencer.sv
// AES job sequencer: one job -> LOAD_KEY / LOAD_TEXT / HASH / WRITE_RESULT on the txn bus.
// Optional ack watchdog enabled by defining SEQ_TIMEOUT_EN.
module aes_txn_sequencer #(
  parameter int         ADDR_W         = 24,
  parameter logic [1:0] MEM_ID         = 2'b00,
  parameter logic [1:0] AES_ID         = 2'b10,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_txn_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     job_count
);
  localparam logic [1:0] OP_KEY  = 2'b00;
  localparam logic [1:0] OP_TXT  = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_HASH = 2'b11;

  typedef enum logic [3:0] {
    IDLE, KEY_REQ, KEY_WAIT, TXT_REQ, TXT_WAIT, HASH_REQ, WR_REQ, WR_WAIT, DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] key_addr;
    logic [ADDR_W-1:0] text_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              encdec;
  } job_t;

  state_e            state_q, state_d, nxt;
  job_t              job_q, job_d;
  logic              key_valid_q, key_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_req, is_wait, adv;
  logic [1:0]        req_op, req_src, req_dst, exp_id;
  logic [ADDR_W-1:0] req_addr;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    key_valid_d = key_valid_q;
    cnt_d       = cnt_q;
    nxt         = state_q;
    is_req      = 1'b0;
    is_wait     = 1'b0;
    adv         = 1'b0;
    req_op      = 2'b00;
    req_src     = 2'b00;
    req_dst     = 2'b00;
    req_addr    = '0;
    exp_id      = MEM_ID;
    done        = 1'b0;
    bus.job_ready     = 1'b0;
    bus.txn_valid     = 1'b0;
    bus.txn_opcode    = 2'b00;
    bus.txn_source_id = 2'b00;
    bus.txn_dest_id   = 2'b00;
    bus.txn_encdec    = 1'b0;
    bus.txn_addr      = '0;
    bus.ack_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        bus.job_ready = 1'b1;
        if (bus.job_valid) begin
          job_d   = '{key_addr: bus.job_key_addr, text_addr: bus.job_text_addr,
                      dst_addr: bus.job_dst_addr, encdec: bus.job_encdec};
          state_d = (bus.job_new_key || !key_valid_q) ? KEY_REQ : TXT_REQ;
        end
      end
      KEY_REQ: begin
        is_req = 1'b1; req_op = OP_KEY; req_src = MEM_ID; req_dst = AES_ID;
        req_addr = job_q.key_addr; nxt = KEY_WAIT;
      end
      TXT_REQ: begin
        is_req = 1'b1; req_op = OP_TXT; req_src = MEM_ID; req_dst = AES_ID;
        req_addr = job_q.text_addr; nxt = TXT_WAIT;
      end
      // HASH has no ack: the write request follows directly.
      HASH_REQ: begin
        is_req = 1'b1; req_op = OP_HASH; req_src = MEM_ID; req_dst = AES_ID;
        req_addr = '0; nxt = WR_REQ;
      end
      WR_REQ: begin
        is_req = 1'b1; req_op = OP_WR; req_src = AES_ID; req_dst = MEM_ID;
        req_addr = job_q.dst_addr; nxt = WR_WAIT;
      end
      KEY_WAIT: begin is_wait = 1'b1; exp_id = MEM_ID; nxt = TXT_REQ; end
      TXT_WAIT: begin is_wait = 1'b1; exp_id = MEM_ID; nxt = HASH_REQ; end
      WR_WAIT:  begin is_wait = 1'b1; exp_id = AES_ID; nxt = DONE; end
      DONE: begin
        done    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (is_req) begin
      bus.txn_valid     = 1'b1;
      bus.txn_opcode    = req_op;
      bus.txn_source_id = req_src;
      bus.txn_dest_id   = req_dst;
      bus.txn_encdec    = job_q.encdec;
      bus.txn_addr      = req_addr;
      adv               = bus.txn_ready;
    end

    // Acks from the wrong module are consumed but do not advance.
    if (is_wait) begin
      bus.ack_ready = 1'b1;
      adv           = bus.ack_valid && (bus.ack_source_id == exp_id);
      if (adv && state_q == KEY_WAIT) key_valid_d = 1'b1;
    end

    if (adv) state_d = nxt;

`ifdef SEQ_TIMEOUT_EN
    wd_d  = (state_d == state_q && (is_req || is_wait)) ? wd_q + 16'd1 : 16'd0;
    err_d = 1'b0;
    if ((is_req || is_wait) && !adv && wd_q == WD_LAST) begin
      state_d     = IDLE;
      key_valid_d = 1'b0;
      err_d       = 1'b1;
      wd_d        = 16'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      job_q       <= '0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      key_valid_q <= key_valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign err = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign job_count = cnt_q;
endmodule

// File: tb/tb_aes_txn_sequencer.sv
// Directed bench for aes_txn_sequencer: transaction-level scoreboard plus literal spot checks.
module tb_aes_txn_sequencer;
  localparam logic [1:0] MEM = 2'b00;
  localparam logic [1:0] AES = 2'b10;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic        enc;
    logic [23:0] addr;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       busy, done, err;
  logic [7:0] job_count;

  aes_txn_sequencer_if #(.ADDR_W(24)) bus ();

  aes_txn_sequencer #(
    .ADDR_W(24), .MEM_ID(MEM), .AES_ID(AES), .TIMEOUT_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .done(done), .err(err), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t cur_txn();
    return '{bus.txn_opcode, bus.txn_source_id, bus.txn_dest_id, bus.txn_encdec, bus.txn_addr};
  endfunction

  // Behavioural model state
  txn_t       exp_q[$];
  logic [1:0] op_log[$];
  logic       in_job, m_key_valid, ack_pend, prev_hold;
  logic [1:0] ack_id;
  logic [7:0] exp_count;
  txn_t       prev_txn;

  // Scoreboard / compare process
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        in_job = 1'b0; m_key_valid = 1'b0; ack_pend = 1'b0; prev_hold = 1'b0;
        ack_id = MEM; exp_count = 8'd0;
      end else begin
`ifdef SEQ_TIMEOUT_EN
        if (err) begin
          in_job = 1'b0; m_key_valid = 1'b0; ack_pend = 1'b0; exp_q.delete();
        end
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif
        chk("busy", 64'(busy), 64'(in_job));
        chk("job_ready", 64'(bus.job_ready), 64'(!in_job));
        chk("job_count", 64'(job_count), 64'(exp_count));
        chk("ack_ready", 64'(bus.ack_ready), 64'(ack_pend));
        if (prev_hold) chk("txn_hold", 64'({bus.txn_valid, cur_txn()}), 64'({1'b1, prev_txn}));
        if (bus.txn_valid && bus.txn_ready) begin
          if (exp_q.size() == 0) chk("txn_unexpected", 64'(cur_txn()), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("txn_fields", 64'(cur_txn()), 64'(e));
          end
          op_log.push_back(bus.txn_opcode);
          ack_pend = (bus.txn_opcode != 2'b11);
          ack_id   = (bus.txn_opcode == 2'b10) ? AES : MEM;
        end
        if (bus.ack_valid && bus.ack_ready && bus.ack_source_id == ack_id) ack_pend = 1'b0;
        prev_hold = bus.txn_valid && !bus.txn_ready;
        prev_txn  = cur_txn();
        if (done) begin
          chk("done_after_all_txn", 64'(exp_q.size()), 64'd0);
          exp_count = exp_count + 8'd1;
          in_job    = 1'b0;
        end
        if (bus.job_valid && bus.job_ready) begin
          in_job = 1'b1;
          if (bus.job_new_key || !m_key_valid)
            exp_q.push_back('{2'b00, MEM, AES, bus.job_encdec, bus.job_key_addr});
          exp_q.push_back('{2'b01, MEM, AES, bus.job_encdec, bus.job_text_addr});
          exp_q.push_back('{2'b11, MEM, AES, bus.job_encdec, 24'h0});
          exp_q.push_back('{2'b10, AES, MEM, bus.job_encdec, bus.job_dst_addr});
          m_key_valid = 1'b1;
        end
      end
    end
  end

  // Bus responder: acks with the id the spec expects after ack_delay wait cycles
  logic       auto_ack  = 1'b0;
  logic       no_wr_ack = 1'b0;
  int         ack_delay = 3;
  logic [1:0] last_op   = 2'b00;
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.txn_valid) last_op = bus.txn_opcode;
      if (auto_ack) begin
        if (!bus.ack_ready) begin
          bus.ack_valid = 1'b0; wcnt = 0;
        end else if (wcnt >= ack_delay && !(no_wr_ack && last_op == 2'b10)) begin
          bus.ack_valid     = 1'b1;
          bus.ack_source_id = (last_op == 2'b10) ? AES : MEM;
        end else wcnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_job(input logic [23:0] k, input logic [23:0] t, input logic [23:0] d,
                           input logic enc, input logic nk);
    int n = 0;
    while (!bus.job_ready && n < 200) begin cyc(1); n++; end
    chk("job_accept_wait", 64'(bus.job_ready), 64'd1);
    bus.job_key_addr = k; bus.job_text_addr = t; bus.job_dst_addr = d;
    bus.job_encdec = enc; bus.job_new_key = nk; bus.job_valid = 1'b1;
    cyc(1);
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.job_ready && n < 200) begin cyc(1); n++; end
    chk("wait_done", 64'(bus.job_ready), 64'd1);
  endtask

  task automatic wait_ack_ready();
    int n = 0;
    while (!bus.ack_ready && n < 50) begin cyc(1); n++; end
    chk("wait_ack_ready", 64'(bus.ack_ready), 64'd1);
  endtask

  task automatic chk_log(input string name, input int len, input logic [7:0] ops);
    logic [7:0] got = 8'd0;
    chk({name, "_len"}, 64'(op_log.size()), 64'(len));
    if (op_log.size() == len) begin
      foreach (op_log[i]) got = {got[5:0], op_log[i]};
      chk(name, 64'(got), 64'(ops));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_key_addr = '0; bus.job_text_addr = '0; bus.job_dst_addr = '0;
    bus.job_encdec = 1'b0; bus.job_new_key = 1'b0;
    bus.txn_ready = 1'b1; bus.ack_valid = 1'b0; bus.ack_source_id = 2'b00;
    cyc(3);
    rst = 1'b0;

    // Reset state
    chk("rst_job_ready", 64'(bus.job_ready), 64'd1);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    chk("rst_txn", 64'({bus.txn_valid, cur_txn(), bus.ack_ready}), 64'd0);
    chk("rst_job_count", 64'(job_count), 64'd0);

    // Stray ack in KEY_WAIT, then reset while in TXT_WAIT
    issue_job(24'h100000, 24'h200010, 24'h300020, 1'b1, 1'b1);
    wait_ack_ready();
    bus.ack_valid = 1'b1; bus.ack_source_id = AES;
    cyc(1);
    bus.ack_valid = 1'b0;
    chk("stray_ack_still_waiting", 64'({bus.ack_ready, bus.txn_valid}), 64'b10);
    bus.ack_valid = 1'b1; bus.ack_source_id = MEM;
    cyc(1);
    bus.ack_valid = 1'b0;
    chk("key_ack_advances", 64'({bus.txn_valid, bus.txn_opcode, bus.txn_addr}), 64'({1'b1, 2'b01, 24'h200010}));
    cyc(1);
    wait_ack_ready();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midjob_rst", 64'({bus.job_ready, busy, bus.txn_valid}), 64'b100);
    chk("midjob_rst_count", 64'(job_count), 64'd0);

    // Full job after reset: key reloads even though new_key=0
    auto_ack = 1'b1; ack_delay = 3;
    op_log.delete();
    issue_job(24'h0000A0, 24'h0000B0, 24'h0000C0, 1'b1, 1'b0);
    wait_done();
    chk_log("seq_job1", 4, 8'b00_01_11_10);
    chk("count_job1", 64'(job_count), 64'd1);

    // Key reuse, with txn_ready held low for 5 cycles in TXT_REQ
    bus.txn_ready = 1'b0;
    op_log.delete();
    issue_job(24'h111111, 24'h0ABCDE, 24'h222222, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("txt_hold_lit", 64'({bus.txn_valid, bus.txn_opcode, bus.txn_addr}), 64'({1'b1, 2'b01, 24'h0ABCDE}));
      cyc(1);
    end
    bus.txn_ready = 1'b1;
    wait_done();
    chk_log("seq_job2", 3, 8'b00_01_11_10);
    chk("count_job2", 64'(job_count), 64'd2);

    // Decrypt with explicit key reload, zero ack latency
    ack_delay = 0;
    op_log.delete();
    issue_job(24'hFFFFE0, 24'hFFFFF0, 24'h000000, 1'b0, 1'b1);
    wait_done();
    chk_log("seq_job3", 4, 8'b00_01_11_10);

    // Counter wrap: 3 + 254 = 257 jobs -> 1
    for (int i = 0; i < 254; i++) begin
      issue_job(24'(i * 32), 24'(24'h1000 + i * 16), 24'(24'h8000 + i), i[0], (i % 3) == 0);
      wait_done();
    end
    chk("count_wrap", 64'(job_count), 64'd1);

`ifdef SEQ_TIMEOUT_EN
    begin
      int k = 0;
      int n = 0;
      no_wr_ack = 1'b1;
      issue_job(24'h000300, 24'h000310, 24'h000320, 1'b1, 1'b0);
      while (!(bus.txn_valid && bus.txn_opcode == 2'b10) && n < 50) begin cyc(1); n++; end
      chk("wr_req_seen", 64'({bus.txn_valid, bus.txn_opcode}), 64'b110);
      cyc(1);
      while (!err && k < 40) begin cyc(1); k++; end
      chk("timeout_cycles", 64'(k), 64'd16);
      chk("timeout_idle", 64'({busy, bus.job_ready}), 64'b01);
      cyc(1);
      chk("err_one_cycle", 64'(err), 64'd0);
      chk("timeout_no_count", 64'(job_count), 64'd1);
      no_wr_ack = 1'b0;
      op_log.delete();
      issue_job(24'h000400, 24'h000410, 24'h000420, 1'b0, 1'b0);
      wait_done();
      chk_log("reload_after_timeout", 4, 8'b00_01_11_10);
    end
`endif

    cyc(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
